// File: rtl/div_exec_ctrl_pkg.sv
// Shared definitions for the iterative RV64M divide/remainder unit:
// func3 encodings of the divide class and the sequencer state type.
package div_exec_ctrl_pkg;

    localparam logic [2:0] F3_DIV  = 3'd4;
    localparam logic [2:0] F3_DIVU = 3'd5;
    localparam logic [2:0] F3_REM  = 3'd6;
    localparam logic [2:0] F3_REMU = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_exec_ctrl_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// The dividend is shifted out of quo_i MSB-first while quotient bits enter at the LSB.
module div_step #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] dvs_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    // Extra top bit: a partial remainder shifted left can exceed DATA_WIDTH bits,
    // and the same bit doubles as the borrow of the trial subtraction.
    always_comb begin
        shifted = {rem_i, quo_i[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, dvs_i};
        if (diff[DATA_WIDTH]) begin
            rem_o = shifted[DATA_WIDTH-1:0];
            quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
        end else begin
            rem_o = diff[DATA_WIDTH-1:0];
            quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_exec_ctrl.sv
// Divide/remainder sequencer beside the execute-stage ALU: holds the pipeline
// while iterating and presents a one-cycle-valid result.
//
// state | meaning
// IDLE  | waiting for a legal divide-class op; special cases resolve here
// BUSY  | one restoring iteration per cycle, counter runs N-1 down to 0
// DONE  | done_o high with the signed/extended result; back to IDLE next cycle
module div_exec_ctrl
    import div_exec_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  valid_i,
    input  logic [2:0]            func3_i,
    input  logic                  word_i,
    input  logic [DATA_WIDTH-1:0] src_1_i,
    input  logic [DATA_WIDTH-1:0] src_2_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    div_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic                  is_rem_q, is_rem_d;
    logic                  word_q, word_d;
    logic                  quo_neg_q, quo_neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  legal, is_signed, is_rem_op, start;
    logic                  neg_a, neg_b, div_zero, ovf;
    logic [DATA_WIDTH-1:0] ext_a, ext_b, mag_a, mag_b, most_neg, special_res;
    logic [DATA_WIDTH-1:0] step_rem, step_quo, q_signed, r_signed;

    function automatic logic [DATA_WIDTH-1:0] sext_word(input logic [DATA_WIDTH-1:0] v,
                                                       input logic w);
        return w ? {{(DATA_WIDTH-32){v[31]}}, v[31:0]} : v;
    endfunction

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        legal     = (func3_i == F3_DIV) || (func3_i == F3_DIVU) ||
                    (func3_i == F3_REM) || (func3_i == F3_REMU);
        is_signed = (func3_i == F3_DIV) || (func3_i == F3_REM);
        is_rem_op = (func3_i == F3_REM) || (func3_i == F3_REMU);
        start     = (state_q == IDLE) && valid_i && !flush_i && legal;

        ext_a = word_i ? {{(DATA_WIDTH-32){is_signed & src_1_i[31]}}, src_1_i[31:0]} : src_1_i;
        ext_b = word_i ? {{(DATA_WIDTH-32){is_signed & src_2_i[31]}}, src_2_i[31:0]} : src_2_i;
        neg_a = is_signed & ext_a[DATA_WIDTH-1];
        neg_b = is_signed & ext_b[DATA_WIDTH-1];
        mag_a = neg_a ? -ext_a : ext_a;
        mag_b = neg_b ? -ext_b : ext_b;

        most_neg = word_i ? {{(DATA_WIDTH-31){1'b1}}, {31{1'b0}}}
                          : {1'b1, {(DATA_WIDTH-1){1'b0}}};
        div_zero = (ext_b == '0);
        ovf      = is_signed && (ext_a == most_neg) && (ext_b == '1);

        if (is_rem_op) special_res = div_zero ? ext_a : '0;
        else           special_res = div_zero ? '1 : ext_a;

        q_signed = quo_neg_q ? -step_quo : step_quo;
        r_signed = rem_neg_q ? -step_rem : step_rem;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        is_rem_d  = is_rem_q;
        word_d    = word_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;
        result_d  = result_q;

        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && legal) begin
                        is_rem_d  = is_rem_op;
                        word_d    = word_i;
                        quo_neg_d = neg_a ^ neg_b;
                        rem_neg_d = neg_a;
                        dvs_d     = mag_b;
                        rem_d     = '0;
                        // W forms: park the 32-bit magnitude at the top so 32 steps consume it
                        quo_d     = word_i ? (mag_a << (DATA_WIDTH-32)) : mag_a;
                        if (div_zero || ovf) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            result_d = sext_word(special_res, word_i);
                        end else begin
                            state_d = BUSY;
                            cnt_d   = word_i ? CNT_W'(31) : CNT_W'(DATA_WIDTH-1);
                        end
                    end
                end
                BUSY: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = sext_word(is_rem_q ? r_signed : q_signed, word_q);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            is_rem_q  <= 1'b0;
            word_q    <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            is_rem_q  <= is_rem_d;
            word_q    <= word_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign stall_o  = start || (state_q == BUSY);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_exec_ctrl.sv
// Directed and randomized checks of div_exec_ctrl against an arithmetic
// reference model of RV64M divide/remainder semantics and latency.
module tb_div_exec_ctrl;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        valid_i;
    logic [2:0]  func3_i;
    logic        word_i;
    logic [63:0] src_1_i;
    logic [63:0] src_2_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [63:0] result_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    div_exec_ctrl #(.DATA_WIDTH(64)) dut (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .valid_i  (valid_i),
        .func3_i  (func3_i),
        .word_i   (word_i),
        .src_1_i  (src_1_i),
        .src_2_i  (src_2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
        longint sa, sb, mn;
        int     a32, b32;
        a32 = a[31:0];
        b32 = b[31:0];
        sa  = w ? longint'(a32) : longint'(a);
        sb  = w ? longint'(b32) : longint'(b);
        mn  = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1'b1;
        return !f3[0] && (sa == mn) && (sb == -1);
    endfunction

    function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        longint      sa, sb, mn;
        int          a32, b32;
        logic [63:0] ua, ub, q, r, res;
        a32 = a[31:0];
        b32 = b[31:0];
        sa  = w ? longint'(a32) : longint'(a);
        sb  = w ? longint'(b32) : longint'(b);
        ua  = w ? {32'd0, a[31:0]} : a;
        ub  = w ? {32'd0, b[31:0]} : b;
        mn  = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        if (ub == 64'd0) begin
            q = '1;
            r = f3[0] ? ua : sa;
        end else if (!f3[0] && sa == mn && sb == -1) begin
            q = sa;
            r = 64'd0;
        end else if (!f3[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        res = f3[1] ? r : q;
        if (w) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] exp_res, got_res;
        int          exp_cyc, cyc, stalls, done_cyc;
        logic        got;
        exp_res = model(f3, w, a, b);
        exp_cyc = is_special(f3, w, a, b) ? 1 : (w ? 33 : 65);
        func3_i = f3;
        word_i  = w;
        src_1_i = a;
        src_2_i = b;
        valid_i = 1'b1;
        cyc = 0; stalls = 0; done_cyc = -1; got = 1'b0; got_res = '0;
        #1;
        if (stall_o) stalls++;
        while (!got && cyc < 200) begin
            @(posedge clk_i); #1;
            cyc++;
            if (done_o) begin
                got = 1'b1;
                done_cyc = cyc;
                got_res = result_o;
                chk({tag, " stall_in_done"}, 64'(stall_o), 64'd0);
            end else if (stall_o) begin
                stalls++;
            end
        end
        chk({tag, " done_seen"}, 64'(got), 64'd1);
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
        chk({tag, " result"}, got_res, exp_res);
        chk({tag, " stall_cycles"}, 64'(stalls), 64'(exp_cyc));
        // valid_i still high across the DONE edge: must not restart
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        #1;
        chk({tag, " done_one_cycle"}, 64'(done_o), 64'd0);
        chk({tag, " no_restart"}, 64'(stall_o), 64'd0);
        chk({tag, " result_hold"}, result_o, exp_res);
    endtask

    initial begin
        logic [2:0]  rf3;
        logic        rw;
        logic [63:0] ra, rb;
        int          dones;

        arstn_i = 1'b0;
        valid_i = 1'b0;
        func3_i = 3'd0;
        word_i  = 1'b0;
        src_1_i = '0;
        src_2_i = '0;
        flush_i = 1'b0;
        #1;
        chk("reset stall", 64'(stall_o), 64'd0);
        chk("reset done", 64'(done_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        #10 arstn_i = 1'b1;
        @(posedge clk_i); #1;

        run_op("DIV 100/7", 3'd4, 1'b0, 64'd100, 64'd7);
        run_op("REM 100/7", 3'd6, 1'b0, 64'd100, 64'd7);
        run_op("DIV -7/2", 3'd4, 1'b0, -64'sd7, 64'd2);
        run_op("REM -7/2", 3'd6, 1'b0, -64'sd7, 64'd2);
        run_op("DIVU max/2", 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run_op("DIVU 5/0", 3'd5, 1'b0, 64'd5, 64'd0);
        run_op("REMU 5/0", 3'd7, 1'b0, 64'd5, 64'd0);
        run_op("DIV ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1);
        run_op("REM ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1);
        run_op("DIVW ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, '1);
        run_op("DIVW hi", 3'd4, 1'b1, 64'h1_0000_0064, 64'd7);
        run_op("REMW neg", 3'd6, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'd2);
        run_op("DIVUW 0", 3'd5, 1'b1, 64'h0000_0000_8000_0001, 64'h1234_5678_0000_0000);

        // Illegal func3: ignored, no stall
        func3_i = 3'd1; word_i = 1'b0; src_1_i = 64'd9; src_2_i = 64'd3; valid_i = 1'b1;
        #1;
        chk("illegal stall", 64'(stall_o), 64'd0);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            if (done_o) dones++;
        end
        chk("illegal no_done", 64'(dones), 64'd0);
        valid_i = 1'b0;

        // Flush beats valid in IDLE
        func3_i = 3'd4; src_1_i = 64'd100; src_2_i = 64'd7; valid_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("flush idle stall", 64'(stall_o), 64'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        // Flush at BUSY cycle 10
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
        end
        chk("busy before flush", 64'(stall_o), 64'd1);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("flush to idle", 64'(stall_o), 64'd0);
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk_i); #1;
            if (done_o) dones++;
        end
        chk("flush no_done", 64'(dones), 64'd0);

        // Async reset mid-BUSY
        func3_i = 3'd5; word_i = 1'b0; src_1_i = 64'd1000; src_2_i = 64'd3; valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        #1;
        chk("busy before reset", 64'(stall_o), 64'd1);
        #1 arstn_i = 1'b0;
        #1;
        chk("arst stall", 64'(stall_o), 64'd0);
        chk("arst done", 64'(done_o), 64'd0);
        chk("arst result", result_o, 64'd0);
        @(negedge clk_i);
        arstn_i = 1'b1;
        @(posedge clk_i); #1;
        run_op("DIV after reset", 3'd4, 1'b0, 64'd100, 64'd7);

        for (int i = 0; i < 24; i++) begin
            rf3 = 3'(4 + $urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = rw ? {$urandom, 32'd0} : 64'd0;
                1: rb = '1;
                2: rb = 64'($urandom_range(1, 15)) * (($urandom_range(0, 1) == 1) ? -64'sd1 : 64'sd1);
                3: ra = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op($sformatf("rnd%0d f3=%0d w=%0d", i, rf3, rw), rf3, rw, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
